// File: rtl/cfs_aligner_stream_pkg.sv
// cfs_aligner_stream_pkg: width helpers, the size/offset legality rule
// and the TX state encoding shared by the streaming aligner files.
package cfs_aligner_stream_pkg;

  function automatic int offset_w(input int bytes);
    return (bytes <= 1) ? 1 : $clog2(bytes);
  endfunction

  function automatic int size_w(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

  function automatic logic is_legal(
    input int unsigned size,
    input int unsigned offset,
    input int unsigned bytes
  );
    return (size != 0) && (offset + size <= bytes);
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/cfs_aligner_stream_bytebuf.sv
// cfs_aligner_stream_bytebuf: 2*BYTES byte FIFO, byte 0 is the oldest.
// Ports: push (data/off/cnt), pop (cnt), count, next count, next head.
module cfs_aligner_stream_bytebuf
  import cfs_aligner_stream_pkg::*;
#(
  parameter int BYTES = 4,
  parameter int OW    = 2,
  parameter int SW    = 3,
  parameter int CW    = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push_en,
  input  logic [BYTES*8-1:0] push_data,
  input  logic [OW-1:0]      push_off,
  input  logic [SW-1:0]      push_cnt,
  input  logic               pop_en,
  input  logic [SW-1:0]      pop_cnt,
  output logic [CW-1:0]      count,
  output logic [CW-1:0]      count_nxt,
  output logic [BYTES*8-1:0] head_nxt
);

  localparam int BW = BYTES * 8;
  localparam int DW = 2 * BW;

  logic [DW-1:0] mem_q;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] kept;
  logic [DW-1:0] placed;
  logic [BW-1:0] mask;
  logic [BW-1:0] sel;
  logic [SW-1:0] push_n;
  logic [SW-1:0] pop_n;
  logic [CW-1:0] base;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Bytes at or above the count are kept zero, so a right shift
  // pops and an OR appends without any per-byte muxing.
  always_comb begin
    push_n = push_en ? push_cnt : '0;
    pop_n  = pop_en ? pop_cnt : '0;
    kept   = mem_q >> {pop_n, 3'b000};
    mask   = ~({BW{1'b1}} << {push_n, 3'b000});
    sel    = (push_data >> {push_off, 3'b000}) & mask;
    base   = cnt_q - {1'b0, pop_n};
    placed = {{BW{1'b0}}, sel} << {base, 3'b000};
    mem_d  = kept | placed;
    cnt_d  = base + {1'b0, push_n};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign count     = cnt_q;
  assign count_nxt = cnt_d;
  assign head_nxt  = mem_d[BW-1:0];

endmodule

// File: rtl/cfs_aligner_stream.sv
// cfs_aligner_stream: repacks MD RX bytes into TX beats of a configured
// size/offset; counts dropped beats. Optional CFS_ALIGNER_STREAM_IRQ_EN.
module cfs_aligner_stream
  import cfs_aligner_stream_pkg::*;
#(
  parameter int  ALGN_DATA_WIDTH   = 32,
  parameter int  CNT_DROP_WIDTH    = 8,
  localparam int BYTES             = ALGN_DATA_WIDTH / 8,
  localparam int ALGN_OFFSET_WIDTH = offset_w(BYTES),
  localparam int ALGN_SIZE_WIDTH   = size_w(BYTES)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ALGN_SIZE_WIDTH-1:0]   ctrl_size,
  input  logic [ALGN_OFFSET_WIDTH-1:0] ctrl_offset,
  output logic                         ctrl_err,
  input  logic                         cnt_drop_clr,
  output logic [CNT_DROP_WIDTH-1:0]    status_cnt_drop,
  input  logic                         md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
  input  logic [ALGN_OFFSET_WIDTH-1:0] md_rx_offset,
  input  logic [ALGN_SIZE_WIDTH-1:0]   md_rx_size,
  output logic                         md_rx_ready,
  output logic                         md_rx_err,
  output logic                         md_tx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]   md_tx_data,
  output logic [ALGN_OFFSET_WIDTH-1:0] md_tx_offset,
  output logic [ALGN_SIZE_WIDTH-1:0]   md_tx_size,
  input  logic                         md_tx_ready,
  input  logic                         md_tx_err,
  output logic                         irq
);

  localparam int OW = ALGN_OFFSET_WIDTH;
  localparam int SW = ALGN_SIZE_WIDTH;
  localparam int CW = SW + 1;
  localparam int DW = ALGN_DATA_WIDTH;
  localparam int NW = CNT_DROP_WIDTH;

  tx_state_e state_q;
  tx_state_e state_d;

  logic [SW-1:0] cfg_size_q;
  logic [SW-1:0] cfg_size_d;
  logic [OW-1:0] cfg_offset_q;
  logic [OW-1:0] cfg_offset_d;
  logic          cfg_upd;

  logic [DW-1:0] tx_data_q;
  logic [DW-1:0] tx_data_d;
  logic [DW-1:0] tx_mask;
  logic [SW-1:0] tx_size_q;
  logic [OW-1:0] tx_offset_q;
  logic          tx_load;
  logic          tx_valid;
  logic          tx_hs;

  logic          rx_ready_q;
  logic          rx_legal;
  logic          rx_hs;
  logic          rx_push;
  logic          rx_drop;

  logic [NW-1:0] cnt_drop_q;
  logic [NW-1:0] cnt_drop_d;

  logic [CW-1:0] buf_count;
  logic [CW-1:0] buf_count_nxt;
  logic [DW-1:0] head_nxt;

  assign ctrl_err = !is_legal(32'(ctrl_size),
                              32'(ctrl_offset),
                              BYTES);
  assign rx_legal = is_legal(32'(md_rx_size),
                             32'(md_rx_offset),
                             BYTES);

  assign rx_hs    = md_rx_valid && rx_ready_q;
  assign rx_push  = rx_hs && rx_legal;
  assign rx_drop  = rx_hs && !rx_legal;
  assign tx_valid = (state_q == SEND);
  assign tx_hs    = tx_valid && md_tx_ready;

  cfs_aligner_stream_bytebuf #(
    .BYTES (BYTES),
    .OW    (OW),
    .SW    (SW),
    .CW    (CW)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_en   (rx_push),
    .push_data (md_rx_data),
    .push_off  (md_rx_offset),
    .push_cnt  (md_rx_size),
    .pop_en    (tx_hs),
    .pop_cnt   (tx_size_q),
    .count     (buf_count),
    .count_nxt (buf_count_nxt),
    .head_nxt  (head_nxt)
  );

  // Config only moves while nothing is buffered or in flight, so a
  // beat is never split across two configurations.
  always_comb begin
    cfg_upd      = (buf_count == '0) && !tx_valid && !ctrl_err;
    cfg_size_d   = cfg_upd ? ctrl_size : cfg_size_q;
    cfg_offset_d = cfg_upd ? ctrl_offset : cfg_offset_q;
  end

  // Decisions use the post-push/pop buffer so a completing RX beat
  // shows up on TX one cycle later.
  always_comb begin
    state_d = state_q;
    tx_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (buf_count_nxt >= {1'b0, cfg_size_d}) begin
          state_d = SEND;
          tx_load = 1'b1;
        end
      end
      SEND: begin
        if (tx_hs) begin
          if (buf_count_nxt >= {1'b0, cfg_size_d}) begin
            tx_load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    tx_mask   = ~({DW{1'b1}} << {cfg_size_d, 3'b000});
    tx_data_d = (head_nxt & tx_mask) << {cfg_offset_d, 3'b000};
  end

  always_comb begin
    cnt_drop_d = cnt_drop_q;
    if (cnt_drop_clr) begin
      cnt_drop_d = '0;
    end else if (rx_drop && !(&cnt_drop_q)) begin
      cnt_drop_d = cnt_drop_q + NW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cfg_size_q   <= SW'(1);
      cfg_offset_q <= '0;
      tx_data_q    <= '0;
      tx_size_q    <= '0;
      tx_offset_q  <= '0;
      rx_ready_q   <= 1'b0;
      cnt_drop_q   <= '0;
    end else begin
      state_q      <= state_d;
      cfg_size_q   <= cfg_size_d;
      cfg_offset_q <= cfg_offset_d;
      if (tx_load) begin
        tx_data_q   <= tx_data_d;
        tx_size_q   <= cfg_size_d;
        tx_offset_q <= cfg_offset_d;
      end
      rx_ready_q <= (buf_count_nxt <= CW'(BYTES));
      cnt_drop_q <= cnt_drop_d;
    end
  end

`ifdef CFS_ALIGNER_STREAM_IRQ_EN
  logic irq_q;
  logic irq_set;

  assign irq_set = ((&cnt_drop_d) && !(&cnt_drop_q))
                 || (tx_hs && md_tx_err);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (cnt_drop_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  logic unused_tx_err;

  assign unused_tx_err = md_tx_err;
  assign irq           = 1'b0;
`endif

  assign md_rx_ready     = rx_ready_q;
  assign md_rx_err       = rx_drop;
  assign md_tx_valid     = tx_valid;
  assign md_tx_data      = tx_data_q;
  assign md_tx_size      = tx_size_q;
  assign md_tx_offset    = tx_offset_q;
  assign status_cnt_drop = cnt_drop_q;

endmodule

// File: tb/tb_cfs_aligner_stream.sv
// tb_cfs_aligner_stream: directed and random stimulus against a
// byte-queue model of the aligner, compared every cycle.
module tb_cfs_aligner_stream;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  ctrl_size = 3'd4;
  logic [1:0]  ctrl_offset = 2'd0;
  logic        ctrl_err;
  logic        cnt_drop_clr = 1'b0;
  logic [7:0]  status_cnt_drop;
  logic        md_rx_valid = 1'b0;
  logic [31:0] md_rx_data = '0;
  logic [1:0]  md_rx_offset = '0;
  logic [2:0]  md_rx_size = '0;
  logic        md_rx_ready;
  logic        md_rx_err;
  logic        md_tx_valid;
  logic [31:0] md_tx_data;
  logic [1:0]  md_tx_offset;
  logic [2:0]  md_tx_size;
  logic        md_tx_ready = 1'b1;
  logic        md_tx_err = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  cfs_aligner_stream dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ctrl_size       (ctrl_size),
    .ctrl_offset     (ctrl_offset),
    .ctrl_err        (ctrl_err),
    .cnt_drop_clr    (cnt_drop_clr),
    .status_cnt_drop (status_cnt_drop),
    .md_rx_valid     (md_rx_valid),
    .md_rx_data      (md_rx_data),
    .md_rx_offset    (md_rx_offset),
    .md_rx_size      (md_rx_size),
    .md_rx_ready     (md_rx_ready),
    .md_rx_err       (md_rx_err),
    .md_tx_valid     (md_tx_valid),
    .md_tx_data      (md_tx_data),
    .md_tx_offset    (md_tx_offset),
    .md_tx_size      (md_tx_size),
    .md_tx_ready     (md_tx_ready),
    .md_tx_err       (md_tx_err),
    .irq             (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit legal4(input int s, input int o);
    return (s != 0) && (o + s <= 4);
  endfunction

  // Behavioural model: a byte queue plus the beat currently offered.
  logic [7:0]  mq[$];
  int          m_cfg_size;
  int          m_cfg_off;
  bit          m_tx_valid;
  logic [31:0] m_tx_data;
  int          m_tx_size;
  int          m_tx_off;
  bit          m_rx_ready;
  int          m_cnt;
  bit          m_irq;

  logic [31:0] log_data[$];
  int          log_size[$];
  int          log_off[$];

  task automatic m_reset();
    mq.delete();
    m_cfg_size = 1;
    m_cfg_off  = 0;
    m_tx_valid = 0;
    m_tx_data  = '0;
    m_tx_size  = 0;
    m_tx_off   = 0;
    m_rx_ready = 0;
    m_cnt      = 0;
    m_irq      = 0;
  endtask

  task automatic m_step();
    bit rx_hs, tx_hs, lg, take, irq_set;
    int rs, ro, cs, co;
    rs    = int'(md_rx_size);
    ro    = int'(md_rx_offset);
    cs    = int'(ctrl_size);
    co    = int'(ctrl_offset);
    rx_hs = md_rx_valid && m_rx_ready;
    lg    = legal4(rs, ro);
    tx_hs = m_tx_valid && md_tx_ready;
    take  = (mq.size() == 0) && !m_tx_valid && legal4(cs, co);
    irq_set = 0;
    if (tx_hs) begin
      for (int i = 0; i < m_tx_size; i++) void'(mq.pop_front());
    end
    if (rx_hs && lg) begin
      for (int i = 0; i < rs; i++)
        mq.push_back(md_rx_data[(ro + i) * 8 +: 8]);
    end
    if (take) begin
      m_cfg_size = cs;
      m_cfg_off  = co;
    end
    if (!m_tx_valid || tx_hs) begin
      if (mq.size() >= m_cfg_size) begin
        m_tx_valid = 1;
        m_tx_size  = m_cfg_size;
        m_tx_off   = m_cfg_off;
        m_tx_data  = '0;
        for (int i = 0; i < m_cfg_size; i++)
          m_tx_data[(m_cfg_off + i) * 8 +: 8] = mq[i];
      end else begin
        m_tx_valid = 0;
      end
    end
    m_rx_ready = (mq.size() <= 4);
`ifdef CFS_ALIGNER_STREAM_IRQ_EN
    irq_set = (rx_hs && !lg && m_cnt == 254 && !cnt_drop_clr)
            || (tx_hs && md_tx_err);
`endif
    if (cnt_drop_clr) m_cnt = 0;
    else if (rx_hs && !lg && m_cnt < 255) m_cnt++;
    if (irq_set) m_irq = 1;
    else if (cnt_drop_clr) m_irq = 0;
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      m_reset();
      chk("rst_tx_valid", md_tx_valid, 0);
      chk("rst_tx_data", md_tx_data, 0);
      chk("rst_tx_size", md_tx_size, 0);
      chk("rst_rx_ready", md_rx_ready, 0);
      chk("rst_cnt_drop", status_cnt_drop, 0);
      chk("rst_irq", irq, 0);
    end else begin
      chk("tx_valid", md_tx_valid, m_tx_valid);
      if (m_tx_valid) begin
        chk("tx_data", md_tx_data, m_tx_data);
        chk("tx_size", md_tx_size, m_tx_size);
        chk("tx_offset", md_tx_offset, m_tx_off);
      end
      chk("rx_ready", md_rx_ready, m_rx_ready);
      chk("rx_err", md_rx_err,
          md_rx_valid && m_rx_ready &&
          !legal4(int'(md_rx_size), int'(md_rx_offset)));
      chk("cnt_drop", status_cnt_drop, m_cnt);
      chk("irq", irq, m_irq);
      chk("ctrl_err", ctrl_err,
          !legal4(int'(ctrl_size), int'(ctrl_offset)));
      if (md_tx_valid && md_tx_ready) begin
        log_data.push_back(md_tx_data);
        log_size.push_back(int'(md_tx_size));
        log_off.push_back(int'(md_tx_offset));
      end
      m_step();
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left just after a rising edge.
  task automatic send(input logic [31:0] d,
                      input int o, input int s);
    int n;
    md_rx_valid  = 1'b1;
    md_rx_data   = d;
    md_rx_offset = 2'(o);
    md_rx_size   = 3'(s);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!md_rx_ready && n < 200);
    if (!md_rx_ready) chk("rx_timeout", md_rx_ready, 1);
    @(posedge clk);
    #1;
    md_rx_valid = 1'b0;
  endtask

  int nlog;
  bit exp_irq;

  initial begin
`ifdef CFS_ALIGNER_STREAM_IRQ_EN
    exp_irq = 1;
`else
    exp_irq = 0;
`endif
    cyc(3);
    reset_n = 1'b1;
    cyc(3);

    // Four single bytes make one 4-byte beat.
    send(32'h0000_00AA, 0, 1);
    send(32'h0000_BB00, 1, 1);
    send(32'h00CC_0000, 2, 1);
    send(32'hDD00_0000, 3, 1);
    chk("t1_valid", md_tx_valid, 1);
    chk("t1_data", md_tx_data, 32'hDDCC_BBAA);
    chk("t1_size", md_tx_size, 4);
    cyc(3);

    // Size 2 at offset 2 from one full beat.
    ctrl_size = 3'd2;
    ctrl_offset = 2'd2;
    cyc(3);
    nlog = log_data.size();
    send(32'h4433_2211, 0, 4);
    cyc(6);
    chk("t2_beats", log_data.size() - nlog, 2);
    chk("t2_data0", log_data[nlog], 32'h2211_0000);
    chk("t2_data1", log_data[nlog + 1], 32'h4433_0000);
    chk("t2_size1", log_size[nlog + 1], 2);
    chk("t2_off1", log_off[nlog + 1], 2);

    // Illegal beats are dropped and counted.
    nlog = log_data.size();
    send(32'h1234_5678, 0, 0);
    send(32'h1234_5678, 3, 2);
    cyc(3);
    chk("t3_cnt", status_cnt_drop, 2);
    chk("t3_no_tx", log_data.size() - nlog, 0);

    // Sink stall while full beats stream in.
    ctrl_size = 3'd4;
    ctrl_offset = 2'd0;
    cyc(3);
    nlog = log_data.size();
    md_tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      md_rx_valid  = 1'b1;
      md_rx_data   = $urandom;
      md_rx_offset = 2'd0;
      md_rx_size   = 3'd4;
      cyc(1);
    end
    md_rx_valid = 1'b0;
    chk("t4_ready_low", md_rx_ready, 0);
    chk("t4_valid", md_tx_valid, 1);
    md_tx_ready = 1'b1;
    cyc(8);
    chk("t4_beats", log_data.size() - nlog, 2);
    chk("t4_drained", md_tx_valid, 0);

    // Size change waits for the buffer to drain.
    nlog = log_data.size();
    send(32'h0033_2211, 0, 3);
    ctrl_size = 3'd2;
    cyc(2);
    send(32'h0000_0044, 0, 1);
    cyc(4);
    send(32'h6655_0000, 2, 2);
    cyc(4);
    chk("t6_beats", log_data.size() - nlog, 2);
    chk("t6_size0", log_size[nlog], 4);
    chk("t6_data0", log_data[nlog], 32'h4433_2211);
    chk("t6_size1", log_size[nlog + 1], 2);
    chk("t6_data1", log_data[nlog + 1], 32'h0000_6655);

    // Counter saturation and clear.
    cnt_drop_clr = 1'b1;
    cyc(1);
    cnt_drop_clr = 1'b0;
    for (int i = 0; i < 256; i++) send(32'h0, 0, 0);
    cyc(1);
    chk("t5_sat", status_cnt_drop, 255);
    chk("t5_irq", irq, exp_irq);
    cnt_drop_clr = 1'b1;
    cyc(1);
    cnt_drop_clr = 1'b0;
    chk("t5_clr", status_cnt_drop, 0);
    chk("t5_irq_clr", irq, 0);

    // Asynchronous reset with a beat in flight.
    ctrl_size = 3'd4;
    md_tx_ready = 1'b0;
    send(32'hCAFE_F00D, 0, 4);
    send(32'hBEEF_0001, 0, 4);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_valid", md_tx_valid, 0);
    chk("rst_async_ready", md_rx_ready, 0);
    cyc(2);
    reset_n = 1'b1;
    md_tx_ready = 1'b1;
    cyc(3);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      md_rx_valid  = ($urandom_range(0, 3) != 0);
      md_rx_data   = $urandom;
      md_rx_offset = 2'($urandom_range(0, 3));
      md_rx_size   = 3'($urandom_range(0, 5));
      md_tx_ready  = ($urandom_range(0, 3) != 0);
      md_tx_err    = ($urandom_range(0, 9) == 0);
      cnt_drop_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 29) == 0) begin
        ctrl_size   = 3'($urandom_range(0, 5));
        ctrl_offset = 2'($urandom_range(0, 3));
      end
      cyc(1);
    end
    md_rx_valid = 1'b0;
    md_tx_ready = 1'b1;
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
